// File: rtl/fp_wb_buffer.sv
// rtl/fp_wb_buffer.sv - FMA result writeback buffer (optional same-cycle bypass via FP_WB_BYPASS_EN)
module fp_wb_buffer #(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = 4,
  parameter int PREG_WIDTH   = 7,
  parameter int ROB_WIDTH    = 4,
  parameter int XLEN         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_en,
  input  logic [PREG_WIDTH-1:0] in_rd,
  input  logic [ROB_WIDTH:0]    in_robIdx,
  input  logic [XLEN-1:0]       in_res,
  input  logic [4:0]            in_exccode,
  input  logic                  redirect,
  input  logic [ROB_WIDTH:0]    redirectIdx,
  input  logic                  out_ready,
  output logic                  out_en,
  output logic [PREG_WIDTH-1:0] out_rd,
  output logic [ROB_WIDTH:0]    out_robIdx,
  output logic [XLEN-1:0]       out_res,
  output logic [4:0]            out_exccode,
  output logic                  issue_stall,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_LV = (AW+1)'(DEPTH - STALL_THRESH);

  logic [PREG_WIDTH-1:0] rd_q  [DEPTH];
  logic [ROB_WIDTH:0]    rob_q [DEPTH];
  logic [XLEN-1:0]       res_q [DEPTH];
  logic [4:0]            exc_q [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [AW-1:0]         head, tail;
  logic [AW:0]           count, count_next;
  logic                  issue_stall_q, overflow_q;

  logic nonempty, full, head_kill, buf_out_en, drain, in_kill;
  logic bypass, pop, head_adv, push_req, push, ovf_set;

  // a is older than b in ROB order; the dir bit flips on every ROB wrap
  function automatic logic older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    else                              return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  // Head/tail control: writeback, bubble drain, kill filtering and push acceptance
  always_comb begin
    nonempty   = (count != '0);
    full       = (count == DEPTH_C);
    head_kill  = redirect & older(redirectIdx, rob_q[head]);
    buf_out_en = valid[head] & nonempty & ~head_kill;
    drain      = nonempty & ~valid[head];
    in_kill    = redirect & older(redirectIdx, in_robIdx);
`ifdef FP_WB_BYPASS_EN
    bypass     = ~nonempty & in_en & ~in_kill & out_ready;
`else
    bypass     = 1'b0;
`endif
    pop        = buf_out_en & out_ready;
    head_adv   = pop | drain;
    push_req   = in_en & ~in_kill & ~bypass;
    push       = push_req & (~full | head_adv);
    ovf_set    = push_req & full & ~head_adv;
    count_next = count + (AW+1)'(push) - (AW+1)'(head_adv);
  end

  // Output mux: stored head entry, or the live input when bypassing an empty buffer
  always_comb begin
    out_en      = buf_out_en | bypass;
    out_rd      = rd_q[head];
    out_robIdx  = rob_q[head];
    out_res     = res_q[head];
    out_exccode = exc_q[head];
    if (bypass) begin
      out_rd      = in_rd;
      out_robIdx  = in_robIdx;
      out_res     = in_res;
      out_exccode = in_exccode;
    end
  end

  // Valid bits: cleared on pop/drain or redirect kill; a push into the freed slot wins
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (head_adv && head == AW'(i))
          valid[i] <= 1'b0;
        else if (redirect && older(redirectIdx, rob_q[i]))
          valid[i] <= 1'b0;
        if (push && tail == AW'(i))
          valid[i] <= 1'b1;
      end
    end
  end

  // Payload storage; no reset needed since valid bits gate visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rd_q[tail]  <= in_rd;
      rob_q[tail] <= in_robIdx;
      res_q[tail] <= in_res;
      exc_q[tail] <= in_exccode;
    end
  end

  // Pointers, occupancy, registered stall and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      issue_stall_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (head_adv) head <= head + 1'b1;
      if (push)     tail <= tail + 1'b1;
      count         <= count_next;
      issue_stall_q <= (count_next > STALL_LV);
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  assign issue_stall = issue_stall_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fp_wb_buffer.sv
// tb/tb_fp_wb_buffer.sv - directed scoreboard bench for fp_wb_buffer
module tb_fp_wb_buffer;

  localparam int DEPTH = 8;
  localparam int STALL_THRESH = 4;
  localparam int PREG_WIDTH = 7;
  localparam int ROB_WIDTH = 4;
  localparam int XLEN = 32;
  localparam int PW = PREG_WIDTH + ROB_WIDTH + 1 + XLEN + 5;
`ifdef FP_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst, in_en, redirect, out_ready;
  logic [PREG_WIDTH-1:0] in_rd, out_rd;
  logic [ROB_WIDTH:0]    in_robIdx, redirectIdx, out_robIdx;
  logic [XLEN-1:0]       in_res, out_res;
  logic [4:0]            in_exccode, out_exccode;
  logic                  out_en, issue_stall, overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] sb [$];

  fp_wb_buffer #(
    .DEPTH(DEPTH), .STALL_THRESH(STALL_THRESH), .PREG_WIDTH(PREG_WIDTH),
    .ROB_WIDTH(ROB_WIDTH), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_rd(in_rd), .in_robIdx(in_robIdx),
    .in_res(in_res), .in_exccode(in_exccode), .redirect(redirect),
    .redirectIdx(redirectIdx), .out_ready(out_ready), .out_en(out_en),
    .out_rd(out_rd), .out_robIdx(out_robIdx), .out_res(out_res),
    .out_exccode(out_exccode), .issue_stall(issue_stall), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [ROB_WIDTH:0] rob, input logic rdy);
    in_en      = en;
    in_robIdx  = rob;
    in_rd      = PREG_WIDTH'($urandom);
    in_res     = $urandom;
    in_exccode = 5'($urandom);
    out_ready  = rdy;
  endtask

  task automatic expect_in();
    sb.push_back({in_rd, in_robIdx, in_res, in_exccode});
  endtask

  // One clock: score any writeback handshake, then advance to the next negedge
  task automatic cycle();
    logic [PW-1:0] want;
    #1;
    if (out_en === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'(out_en), 64'd0);
      end else begin
        want = sb.pop_front();
        check("wb_payload", 64'({out_rd, out_robIdx, out_res, out_exccode}), 64'(want));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirectIdx = '0;
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    #1;
    check("rst_out_en", 64'(out_en), 64'd0);
    check("rst_stall", 64'(issue_stall), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(dut.count), 64'd0);

    // Single result, latency 1 (or 0 with bypass)
    set_in(1'b1, 5'b0_0011, 1'b1);
    in_rd = 7'd5; in_res = 32'h3F80_0000; in_exccode = 5'd0;
    expect_in();
    #1 check("lat_same_cycle_out_en", 64'(out_en), 64'(BYP));
    cycle();
    set_in(1'b0, '0, 1'b1);
    #1 check("lat_next_cycle_out_en", 64'(out_en), 64'(!BYP));
    cycle();
    check("lat_count_zero", 64'(dut.count), 64'd0);

    // Fill to DEPTH with no grant; stall after the 5th push; 9th overflows
    for (int k = 1; k <= DEPTH; k++) begin
      set_in(1'b1, {1'b0, 4'(k - 1)}, 1'b0);
      expect_in();
      cycle();
      check($sformatf("stall_after_push%0d", k), 64'(issue_stall), 64'(k > 4));
    end
    check("fill_count", 64'(dut.count), 64'd8);
    check("fill_no_overflow", 64'(overflow), 64'd0);
    set_in(1'b1, 5'b0_1000, 1'b0);
    cycle();
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(dut.count), 64'd8);
    set_in(1'b0, '0, 1'b1);
    repeat (DEPTH) cycle();
    check("ovf_drain_count", 64'(dut.count), 64'd0);
    check("ovf_drain_stall", 64'(issue_stall), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_sb_empty", 64'(sb.size()), 64'd0);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_clears_overflow", 64'(overflow), 64'd0);

    // Full buffer: simultaneous push and pop keeps count and order
    for (int k = 0; k < DEPTH; k++) begin
      set_in(1'b1, {1'b0, 4'(k)}, 1'b0);
      expect_in();
      cycle();
    end
    set_in(1'b1, 5'b0_1000, 1'b1);
    expect_in();
    cycle();
    check("full_pushpop_count", 64'(dut.count), 64'd8);
    check("full_pushpop_overflow", 64'(overflow), 64'd0);
    set_in(1'b0, '0, 1'b1);
    repeat (DEPTH) cycle();
    check("full_drain_count", 64'(dut.count), 64'd0);
    check("full_sb_empty", 64'(sb.size()), 64'd0);

    // Redirect kills younger entries; killed slots drain as bubbles
    set_in(1'b1, 5'b0_0010, 1'b0); expect_in(); cycle();
    set_in(1'b1, 5'b0_0100, 1'b0); cycle();
    set_in(1'b1, 5'b0_0110, 1'b0); cycle();
    set_in(1'b0, '0, 1'b1);
    redirect = 1'b1; redirectIdx = 5'b0_0011;
    #1 check("redir_head_kept", 64'(out_en), 64'd1);
    cycle();
    redirect = 1'b0;
    #1 check("bubble1_out_en", 64'(out_en), 64'd0);
    check("bubble1_count", 64'(dut.count), 64'd2);
    cycle();
    check("bubble2_out_en", 64'(out_en), 64'd0);
    check("bubble2_count", 64'(dut.count), 64'd1);
    cycle();
    check("bubble_done_count", 64'(dut.count), 64'd0);

    // Wrap-aware age compare: {0,14} is older than {1,1}; equal index survives
    set_in(1'b1, 5'b1_0001, 1'b0); cycle();
    set_in(1'b0, '0, 1'b1);
    redirect = 1'b1; redirectIdx = 5'b0_1110;
    #1 check("wrap_kill_out_en", 64'(out_en), 64'd0);
    cycle();
    redirect = 1'b0;
    cycle();
    check("wrap_kill_count", 64'(dut.count), 64'd0);
    set_in(1'b1, 5'b1_0001, 1'b0); expect_in(); cycle();
    set_in(1'b0, '0, 1'b1);
    redirect = 1'b1; redirectIdx = 5'b1_0001;
    #1 check("equal_idx_kept", 64'(out_en), 64'd1);
    cycle();
    // Incoming result killed by a concurrent redirect is never stored
    set_in(1'b1, 5'b0_0101, 1'b1);
    redirectIdx = 5'b0_0011;
    #1 check("in_kill_out_en", 64'(out_en), 64'd0);
    cycle();
    redirect = 1'b0;
    set_in(1'b0, '0, 1'b1);
    #1 check("in_kill_count", 64'(dut.count), 64'd0);
    check("in_kill_no_out", 64'(out_en), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_wb_buffer.md
FP_WB_BUFFER -- requirements
Module: fp_wb_buffer

Interface
- REQ-001 SHALL have parameter DEPTH, default 8, number of result entries; power of 2, at least 4.
- REQ-002 SHALL have parameter STALL_THRESH, default 4, the maximum number of FMA results that can be in flight behind issue.
- REQ-003 SHALL have port clk, input, 1 bit, the single clock.
- REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
- REQ-005 SHALL have port in_en, input, 1 bit, FMA result valid; there is no backpressure on this input.
- REQ-006 SHALL have ports in_rd (PREG_WIDTH), in_robIdx (ROB_WIDTH+1, {dir, idx}), in_res (XLEN) and in_exccode (5, FFlags), all inputs, carrying the result payload.
- REQ-007 SHALL have ports redirect (1) and redirectIdx (ROB_WIDTH+1), inputs, the backend flush request.
- REQ-008 SHALL have port out_ready, input, 1 bit, writeback port grant.
- REQ-009 SHALL have ports out_en (1), out_rd, out_robIdx, out_res and out_exccode, outputs, the writeback payload.
- REQ-010 SHALL have port issue_stall, output, 1 bit, which blocks new FMA issue.
- REQ-011 SHALL have port overflow, output, 1 bit, a sticky error flag.

Function
- REQ-012 SHALL implement a circular FIFO with head pointer, tail pointer, count (0..DEPTH) and a per-entry valid bit; pointers SHALL wrap modulo DEPTH.
- REQ-013 Push: in_en SHALL write the payload at tail, set its valid bit and advance tail, unless the incoming result is killed (REQ-017).
- REQ-014 Output: out_en SHALL equal valid[head] & (count>0) & ~kill[head]; the payload SHALL come from the head entry (combinational from storage).
- REQ-015 Pop: when out_en & out_ready, head SHALL advance and the entry SHALL be cleared; out_en & ~out_ready SHALL hold the payload stable.
- REQ-016 Bubble drain: when count>0 and the head entry is invalid, head SHALL advance one entry per cycle and out_en SHALL be 0.
- REQ-017 Kill rule: an entry or incoming result is killed when redirect=1 and redirectIdx is strictly older than its robIdx.
  - Older(a,b) is a.idx<b.idx when a.dir==b.dir, and a.idx>b.idx otherwise.
  - Equal robIdx SHALL NOT be killed.
- REQ-018 Killed stored entries SHALL have their valid bit cleared in the redirect cycle but SHALL keep their slot; count is reduced only by pop or drain.
- REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when count==DEPTH.
- REQ-020 Push with count==DEPTH and no pop SHALL drop the result, set overflow and leave state unchanged.
- REQ-021 Base latency is 1: a push in cycle t appears on out_en in cycle t+1 when it is the only entry.
- REQ-022 issue_stall SHALL be registered, equal to 1 when next-cycle count > DEPTH-STALL_THRESH, and otherwise 0.
- REQ-023 Payload fields SHALL pass through bit-exact, with no width conversion.

Reset
- REQ-024 On rst=1 at a clock edge, head, tail, count and all valid bits SHALL go to 0, and out_en, issue_stall and overflow SHALL go to 0 the following cycle.
- REQ-025 rst SHALL override push, pop and redirect in the same cycle; in-flight inputs during reset SHALL be discarded.

Configuration
- REQ-026 The macro FP_WB_BYPASS_EN SHALL select the empty-buffer bypass.
- REQ-027 With FP_WB_BYPASS_EN defined: when count==0, in_en=1, the input is not killed and out_ready=1, the input SHALL drive the outputs in the same cycle with out_en=1 and SHALL NOT be written.
  - If out_ready=0, the input SHALL be pushed normally.
- REQ-028 Without FP_WB_BYPASS_EN: no combinational path from in_* to out_*; latency per REQ-021.

Verification
- REQ-029 Reset, then push rd=5, robIdx={0,3}, res=0x3F800000, exccode=0 with out_ready=1 -> out_en=1 next cycle with identical fields; count returns to 0.
- REQ-030 out_ready=0, push 8 results on consecutive cycles -> count=8; issue_stall=1 after the 5th push; a 9th push sets overflow=1 and is dropped.
- REQ-031 Entries robIdx {0,2},{0,4},{0,6}, then redirect with redirectIdx={0,3} -> only {0,2} is written back; two drain bubbles follow; count reaches 0.
- REQ-032 Wrap order: entry robIdx {1,1}, redirectIdx {0,14} (ROB_WIDTH=4) -> entry is killed; redirectIdx {1,1} -> entry is kept.
- REQ-033 Full buffer, out_ready=1 and in_en=1 in the same cycle -> count stays 8, overflow stays 0, FIFO order is preserved.
- REQ-034 With FP_WB_BYPASS_EN, empty buffer, in_en=1 and out_ready=1 -> out_en=1 in the same cycle and count stays 0; without the macro -> out_en=1 one cycle later.
